mul_share_ctrl: RTL

//  Shares one combinational 64x64->128 unsigned multiplier between two requesters.

---
 rtl/mul_share_ctrl_pkg.sv | 34 +++
 rtl/mul_share_ctrl_if.sv | 54 +++++
 rtl/mul_share_ctrl_core.sv | 20 ++
 rtl/mul_share_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mul_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_ctrl_pkg
// Purpose  : Shared op encodings, FSM state type and sign helpers for the
//            shared multiplier controller.
// Revision : 1.0 - initial release
// ============================================================================
package mul_share_ctrl_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int TAG_W_DEF = 4;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // MUL is treated as unsigned: the low half does not depend on signedness.
    function automatic logic a_is_signed(input logic [1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic b_is_signed(input logic [1:0] op);
        return (op == OP_MULH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_ctrl_if
// Purpose  : Two requester ports and one response port of the shared
//            multiplier controller.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_share_ctrl_if
    import mul_share_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) ();

    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [TAG_W-1:0] resp_tag;
    logic [WIDTH-1:0] resp_data;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  req1_ready,
        input  resp_valid, resp_id, resp_tag, resp_data,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output req1_ready,
        output resp_valid, resp_id, resp_tag, resp_data,
        input  resp_ready
    );

endinterface
`default_nettype wire

// File: rtl/mul_share_ctrl_core.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_ctrl_core
// Purpose  : Combinational unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_ctrl_core
    import mul_share_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod
);

    assign prod = {{WIDTH{1'b0}}, mcand} * {{WIDTH{1'b0}}, b};

endmodule
`default_nettype wire

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_ctrl
// Purpose  : Round-robin sharing of one unsigned multiplier between two
//            requesters, with RISC-V MUL/MULH/MULHSU/MULHU decode.
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_ctrl
    import mul_share_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mul_share_ctrl_if.slave bus
);

    state_e               r_state;
    state_e               w_next;
    logic                 r_last_grant;
    logic                 w_any;
    logic                 w_grant;
    logic                 w_accept;
    logic [1:0]           w_op;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic                 r_neg;
    logic [1:0]           r_op;
    logic                 r_id;
    logic [TAG_W-1:0]     r_tag;
    logic [WIDTH-1:0]     r_data;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_p;

    // On a tie the requester that did not win last time is granted.
    assign w_any   = bus.req0_valid | bus.req1_valid;
    assign w_grant = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;

    assign w_op  = w_grant ? bus.req1_op  : bus.req0_op;
    assign w_a   = w_grant ? bus.req1_a   : bus.req0_a;
    assign w_b   = w_grant ? bus.req1_b   : bus.req0_b;
    assign w_tag = w_grant ? bus.req1_tag : bus.req0_tag;

    assign w_sa = w_a[WIDTH-1] & a_is_signed(w_op);
    assign w_sb = w_b[WIDTH-1] & b_is_signed(w_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_accept       = 1'b1;
                    bus.req0_ready = ~w_grant;
                    bus.req1_ready = w_grant;
                    w_next         = S_MUL;
                end
            end
            S_MUL: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    mul_share_ctrl_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .mcand (r_mag_a),
        .b     (r_mag_b),
        .prod  (w_prod)
    );

    // Most-negative operand negates to itself, which reads as 2^(WIDTH-1) unsigned.
    assign w_p = r_neg ? -w_prod : w_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_mag_a      <= '0;
            r_mag_b      <= '0;
            r_neg        <= 1'b0;
            r_op         <= OP_MUL;
            r_id         <= 1'b0;
            r_tag        <= '0;
            r_data       <= '0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant;
                r_mag_a      <= w_sa ? -w_a : w_a;
                r_mag_b      <= w_sb ? -w_b : w_b;
                r_neg        <= w_sa ^ w_sb;
                r_op         <= w_op;
                r_id         <= w_grant;
                r_tag        <= w_tag;
            end
            if (r_state == S_MUL) begin
                r_data <= (r_op == OP_MUL) ? w_p[WIDTH-1:0] : w_p[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_id    = r_id;
    assign bus.resp_tag   = r_tag;
    assign bus.resp_data  = r_data;

endmodule
`default_nettype wire
